a2o_wb_arb: RTL

A2O_WB_ARB -- requirements
Module: a2o_wb_arb

---
 rtl/a2o_wb_arb_if.sv | 38 +++
 rtl/a2o_wb_arb.sv | 119 +++++++++++
 2 files changed

// File: rtl/a2o_wb_arb_if.sv
// Wishbone arbiter bundle: NUM_M upstream masters plus one downstream slave port.
// Ports: m_cyc/m_stb/m_we/m_adr/m_sel/m_datw in, m_ack/m_err/m_datr out (master side);
//        wb_* downstream bus, gnt one-hot grant. Modport master = arbiter view, slave = environment view.
interface a2o_wb_arb_if #(
    parameter int NUM_M = 4
);
    // upstream master side (master i occupies slice i of each packed vector)
    logic [NUM_M-1:0]    m_cyc;
    logic [NUM_M-1:0]    m_stb;
    logic [NUM_M-1:0]    m_we;
    logic [NUM_M*32-1:0] m_adr;
    logic [NUM_M*4-1:0]  m_sel;
    logic [NUM_M*32-1:0] m_datw;
    logic [NUM_M-1:0]    m_ack;
    logic [NUM_M-1:0]    m_err;
    logic [31:0]         m_datr;
    // downstream slave side
    logic                wb_cyc;
    logic                wb_stb;
    logic                wb_we;
    logic [31:0]         wb_adr;
    logic [3:0]          wb_sel;
    logic [31:0]         wb_datw;
    logic                wb_ack;
    logic [31:0]         wb_datr;
    // current grant
    logic [NUM_M-1:0]    gnt;

    modport master (
        input  m_cyc, m_stb, m_we, m_adr, m_sel, m_datw, wb_ack, wb_datr,
        output m_ack, m_err, m_datr, wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_datw, gnt
    );

    modport slave (
        output m_cyc, m_stb, m_we, m_adr, m_sel, m_datw, wb_ack, wb_datr,
        input  m_ack, m_err, m_datr, wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_datw, gnt
    );
endinterface

// File: rtl/a2o_wb_arb.sv
// Round-robin Wishbone arbiter: NUM_M masters onto one slave, grant held for whole cyc.
// Ports: clk, rst (sync, active-high), bus (a2o_wb_arb_if.master). One cycle grant latency, one idle cycle between grants.
// Optional watchdog enabled by macro A2O_WB_ARB_TIMEOUT_EN: stalled strobe for TIMEOUT cycles errors the master out.
module a2o_wb_arb #(
    parameter int NUM_M   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    a2o_wb_arb_if.master   bus
);

    localparam int LW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUS  = 1'b1;

    logic [0:0]    state_q, state_d;
    // Current grant while in BUS; holds the last granted master while in IDLE.
    logic [LW-1:0] gidx_q, gidx_d;
    logic [LW-1:0] pick;
    logic          bus_act;
    logic          g_cyc;
    logic          wd_fire;

    // Outputs are qualified with !rst so nothing leaks during the reset cycle itself.
    assign bus_act = (state_q == BUS) && !rst;
    assign g_cyc   = bus.m_cyc[gidx_q];

    // First requester searching upward from last grant + 1, wrapping.
    always_comb begin
        logic          found;
        int            idx;
        logic [LW-1:0] ci;
        pick  = gidx_q;
        found = 1'b0;
        idx   = 0;
        ci    = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = int'(gidx_q) + k;
            if (idx >= NUM_M) idx = idx - NUM_M;
            ci = LW'(idx);
            if (!found && bus.m_cyc[ci]) begin
                pick  = ci;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        case (state_q)
            IDLE: begin
                if (|bus.m_cyc) begin
                    state_d = BUS;
                    gidx_d  = pick;
                end
            end
            default: begin
                if (wd_fire || !g_cyc) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gidx_q  <= LW'(NUM_M - 1);
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
        end
    end

`ifdef A2O_WB_ARB_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;

    // Fires on the registered count so the slave-side strobe drop does not
    // depend combinationally on wb_ack.
    assign wd_fire = bus_act && (wd_q == 16'(TIMEOUT));

    always_comb begin
        wd_d = wd_q;
        if (state_q != BUS || state_d != BUS || bus.wb_ack) wd_d = '0;
        else if (bus.wb_stb) wd_d = wd_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`else
    assign wd_fire = 1'b0;
`endif

    assign bus.m_datr = bus.wb_datr;

    always_comb begin
        bus.gnt     = '0;
        bus.m_ack   = '0;
        bus.m_err   = '0;
        bus.wb_cyc  = bus_act && g_cyc && !wd_fire;
        bus.wb_stb  = bus_act && bus.m_stb[gidx_q] && !wd_fire;
        bus.wb_we   = bus_act && bus.m_we[gidx_q];
        bus.wb_adr  = bus.m_adr[gidx_q*32 +: 32];
        bus.wb_sel  = bus.m_sel[gidx_q*4 +: 4];
        bus.wb_datw = bus.m_datw[gidx_q*32 +: 32];
        if (bus_act) begin
            bus.gnt[gidx_q]   = 1'b1;
            bus.m_ack[gidx_q] = bus.wb_ack;
`ifdef A2O_WB_ARB_TIMEOUT_EN
            // A late ack in the firing cycle still completes the beat normally.
            bus.m_err[gidx_q] = wd_fire && !bus.wb_ack;
`endif
        end
    end

endmodule
